demux_stream: RTL
=================

Name: demux_stream

Overview:
- Parametrised successor of the team's 4-way demux: a registered 1-to-N stream demultiplexer, DATA_W bits wide, with valid/ready handshakes on the input and on every output channel.
- Each output channel has a one-entry holding register, so a stalled channel never blocks traffic routed to the other channels.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- N_CH, 4: number of output channels; legal range 2..16.
- DATA_W, 1: payload width in bits.
- SEL_W, $clog2(N_CH): width of the select field.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  N_CH  per-channel valid.
- out_ready  input  N_CH  per-channel consumer ready.
- sel_err  output  1  one-cycle pulse when a beat with in_sel >= N_CH is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state resets immediately on rst_n low, with no clock required.
- Reset values: out_valid = 0, out_data = 0, sel_err = 0. in_ready reflects the empty channels, so it is 1 out of reset when in_sel is in range.
- Per channel k, the state machine has two states:
  - EMPTY -> FULL on accept with in_sel==k.
  - FULL -> EMPTY on out_ready[k] with no new accept to k.
  - FULL stays FULL on drain plus simultaneous accept to k; this is a pass-through refill.
- out_valid[k] = (state k == FULL).
- in_ready is combinational:
  - in_sel < N_CH: in_ready = (state[in_sel]==EMPTY) | out_ready[in_sel].
  - in_sel >= N_CH: in_ready = 1.
- Accept = in_valid & in_ready. On accept, in_data is loaded into the holding register of channel in_sel at the clock edge.
- Latency: accept in cycle t gives out_valid[k]=1 in cycle t+1. Sustained throughput is 1 beat per cycle per channel when out_ready is held high.
- Data stability:
  - While out_valid[k]=1 and out_ready[k]=0, out_data slice k holds.
  - Other channels' slices never change due to traffic to k.
  - An EMPTY channel holds its last data; consumers must ignore it.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready to in_ready is through the selected channel.
- Out-of-range select (only possible when N_CH is not a power of two):
  - The beat is accepted and dropped.
  - No channel state changes.
  - sel_err pulses high for one cycle, in the cycle after the accept.
- Producer rule: in_data and in_sel must be held while in_valid=1 and in_ready=0. The block does not check this.
- Reset mid-operation: all held beats are discarded, out_valid drops asynchronously, and there is no partial delivery after reset release.
- in_sel may change every cycle. Ordering is preserved per channel; there is no ordering guarantee across channels.

Optional Feature:
- Macro: DEMUX_STREAM_BCAST_EN.
- When defined, the block adds an input port in_bcast (1 bit).
  - A beat with in_bcast=1 is accepted only when every channel is EMPTY or draining this cycle.
  - On accept, it loads all N_CH holding registers and in_sel is ignored.
  - sel_err never pulses for a broadcast beat.
- When undefined, the port does not exist and all beats are unicast as described above.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle while channels 1 and 3 are FULL.
  - Required response: out_valid=4'b0000 immediately. After release, out_data=0 and in_ready=1.
- Basic routing (N_CH=4, DATA_W=8):
  - Stimulus: send 0xA5 to sel=2, with all out_ready=1.
  - Required response: next cycle out_valid=4'b0100 and out_data[23:16]=0xA5; the following cycle out_valid=0.
- Backpressure isolation:
  - Stimulus: out_ready[0]=0. Send 0x11 then 0x22 to sel=0, then 0x33 to sel=1.
  - Required response: 0x11 is held on ch0 and in_ready=0 while 0x22 is presented. After switching in_sel to 1, 0x33 is delivered on ch1 one cycle later. Raising out_ready[0] then admits 0x22.
- Full throughput:
  - Stimulus: stream 0..15 to sel=3 with out_ready[3]=1 on every cycle.
  - Required response: 16 beats in 16 cycles on ch3, in order. Then toggle out_ready[3] in a 1010 pattern: no beat is lost or duplicated.
- Out-of-range select (N_CH=3):
  - Stimulus: send a beat with in_sel=3.
  - Required response: in_ready=1, sel_err pulses once, and out_valid stays 3'b000.
- Broadcast (DEMUX_STREAM_BCAST_EN defined):
  - Stimulus: with ch2 FULL and stalled, send in_bcast=1 with data 0x5A.
  - Required response: in_ready=0 until ch2 drains. Then all out_valid=1 with 0x5A on every slice.

Source files
------------

// File: rtl/demux_stream_if.sv
// Stream bus for demux_stream: a single producer port in, N_CH consumer channels out.
// The in_bcast signal exists only when DEMUX_STREAM_BCAST_EN is defined.
interface demux_stream_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = $clog2(N_CH)
);
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic                   sel_err;
`ifdef DEMUX_STREAM_BCAST_EN
    logic                   in_bcast;

    modport slave (
        input  in_data, in_sel, in_valid, in_bcast, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

    modport master (
        output in_data, in_sel, in_valid, in_bcast, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );
`else
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );
`endif
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Optional broadcast beats (in_bcast) are enabled by defining DEMUX_STREAM_BCAST_EN.
module demux_stream #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_if.slave  bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    ch_state_t         r_state [N_CH];
    logic [DATA_W-1:0] r_data  [N_CH];
    logic              r_sel_err;

    logic              w_in_range;
    logic              w_bcast;
    logic              w_sel_ready;
    logic              w_in_ready;
    logic              w_accept;
    logic [N_CH-1:0]   w_free;
    logic [N_CH-1:0]   w_load;

`ifdef DEMUX_STREAM_BCAST_EN
    assign w_bcast = bus.in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Input-side handshake: only the selected channel's out_ready reaches in_ready (all of them for broadcast).
    always_comb begin
        w_in_range  = ({1'b0, bus.in_sel} < N_CH_L);
        w_sel_ready = 1'b0;
        w_free      = '0;
        w_load      = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_free[k]   = (r_state[k] == ST_EMPTY) | bus.out_ready[k];
            w_sel_ready = w_sel_ready | (w_free[k] & (bus.in_sel == SEL_W'(k)));
        end
        if (w_bcast) begin
            w_in_ready = &w_free;
        end else if (w_in_range) begin
            w_in_ready = w_sel_ready;
        end else begin
            w_in_ready = 1'b1;
        end
        w_accept = bus.in_valid & w_in_ready;
        for (int k = 0; k < N_CH; k++) begin
            w_load[k] = w_accept & (w_bcast | (bus.in_sel == SEL_W'(k)));
        end
    end

    assign bus.in_ready = w_in_ready;

    // Per-channel EMPTY/FULL state; a drain and a refill in the same cycle keeps the channel FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= ST_EMPTY;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                case (r_state[k])
                    ST_EMPTY: begin
                        if (w_load[k]) begin
                            r_state[k] <= ST_FULL;
                        end else begin
                            r_state[k] <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_load[k]) begin
                            r_state[k] <= ST_FULL;
                        end else if (bus.out_ready[k]) begin
                            r_state[k] <= ST_EMPTY;
                        end else begin
                            r_state[k] <= ST_FULL;
                        end
                    end
                    default: begin
                        r_state[k] <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    // Holding registers keep their last payload after draining; only a load changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= bus.in_data;
                end else begin
                    r_data[k] <= r_data[k];
                end
            end
        end
    end

    // Out-of-range unicast beats are swallowed and flagged one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_accept & ~w_in_range & ~w_bcast;
        end
    end

    // Outputs are taken straight from the state and holding registers.
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.out_data[k*DATA_W +: DATA_W] = r_data[k];
            bus.out_valid[k]                 = (r_state[k] == ST_FULL);
        end
    end

    assign bus.sel_err = r_sel_err;

endmodule
